// File: rtl/sd_spi_master.sv
// SD-card SPI-mode initiator: one byte per command, power-up clock burst
// and chip-select control behind a start/busy/done handshake.
module sd_spi_master #(
  parameter int DIV_SLOW    = 125,
  parameter int DIV_FAST    = 1,
  parameter int INIT_CLOCKS = 80
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  input  logic       fast,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int MAXDIV = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CW     = $clog2(MAXDIV) + 1;
  localparam int NEDGE  = (2 * INIT_CLOCKS > 16) ? 2 * INIT_CLOCKS : 16;
  localparam int EW     = $clog2(NEDGE) + 1;

  localparam logic [CW-1:0] HS = CW'(DIV_SLOW);
  localparam logic [CW-1:0] HF = CW'(DIV_FAST);

  typedef enum logic [1:0] {IDLE, XFER, INIT, FINISH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] h_q, h_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic [EW-1:0] last;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    ecnt_d  = ecnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    last    = (state_q == XFER) ? EW'(15) : EW'(2 * INIT_CLOCKS - 1);
    unique case (state_q)
      XFER, INIT: begin
        if (cnt_q == '0) begin
          sclk_d = ~sclk_q;
          cnt_d  = h_q - CW'(1);
          ecnt_d = ecnt_q + EW'(1);
          if (!sclk_q) begin
            if (state_q == XFER) rx_d = {rx_q[6:0], spi_miso};
          end else if (ecnt_q == last) begin
            // final falling edge: sclk is already low, go straight to done
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            mosi_d  = 1'b1;
            if (state_q == XFER) dout_d = rx_q;
          end else if (state_q == XFER) begin
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          case (cmd)
            2'd1: begin
              state_d = XFER;
              busy_d  = 1'b1;
              h_d     = fast ? HF : HS;
              cnt_d   = (fast ? HF : HS) - CW'(1);
              ecnt_d  = '0;
              tx_d    = din;
              mosi_d  = din[7];
              sclk_d  = 1'b0;
            end
            2'd2: begin
              state_d = INIT;
              busy_d  = 1'b1;
              h_d     = HS;
              cnt_d   = HS - CW'(1);
              ecnt_d  = '0;
              cs_d    = 1'b1;
              mosi_d  = 1'b1;
              sclk_d  = 1'b0;
            end
            2'd3: begin
              cs_d   = din[0];
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= HS;
      ecnt_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      ecnt_q  <= ecnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_cs   = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule
